// File: rtl/cm_arb_burst_ctrl.sv
// Per-slave-port AHB-Lite arbitration sequencer: holds ownership across bursts and locked tenures.
// Optional CM_ARB_INCR_LIMIT_EN caps undefined-length INCR tenure at INCR_MAX_BEATS accepted beats.
module cm_arb_burst_ctrl #(
   parameter int unsigned REQ_NUM        = 2,
   parameter int unsigned PRI_WIDTH      = 2,
   parameter int unsigned INCR_MAX_BEATS = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [REQ_NUM-1:0]             req,
   input  logic [PRI_WIDTH*REQ_NUM-1:0]   pri,
   input  logic [2*REQ_NUM-1:0]           htrans,
   input  logic [3*REQ_NUM-1:0]           hburst,
   input  logic [REQ_NUM-1:0]             hmastlock,
   input  logic                           hready,
   output logic [REQ_NUM-1:0]             addr_sel,
   output logic [REQ_NUM-1:0]             data_sel,
   output logic                           locked
);

   localparam int unsigned IdxW = $clog2(REQ_NUM);

   localparam logic [1:0] TrIdle   = 2'b00;
   localparam logic [1:0] TrBusy   = 2'b01;
   localparam logic [1:0] TrNonseq = 2'b10;
   localparam logic [1:0] TrSeq    = 2'b11;
   localparam logic [2:0] BurstSingle = 3'b000;
   localparam logic [2:0] BurstIncr   = 3'b001;

   if (REQ_NUM < 2 || REQ_NUM > 16 || INCR_MAX_BEATS < 1) begin : g_bad_cfg
      $error("cm_arb_burst_ctrl: unsupported parameter set");
   end

   typedef enum logic [0:0] {StIdle, StOwn} state_e;

   state_e              state_q, state_d;
   logic [REQ_NUM-1:0]  addr_sel_q, addr_sel_d;
   logic [REQ_NUM-1:0]  data_sel_q;
   logic                locked_q, locked_d;
   logic [3:0]          beats_q, beats_d;
   logic                incr_open_q, incr_open_d;
   logic [IdxW-1:0]     rr_q, rr_d;

   logic                 win_found;
   logic [IdxW-1:0]      win_idx;
   logic [PRI_WIDTH-1:0] win_pri;
   logic [IdxW-1:0]      cand_idx;
   logic [1:0]           own_htrans;
   logic [2:0]           own_hburst;
   logic                 own_lock;
   logic                 tenure_end;
   logic                 force_end;

`ifdef CM_ARB_INCR_LIMIT_EN
   localparam int unsigned IncrCntW = $clog2(INCR_MAX_BEATS + 1);
   logic [IncrCntW-1:0] incr_cnt_q, incr_cnt_d;
`endif

   // Highest priority wins; ties go to the first requester found after the last owner.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      win_pri   = '0;
      cand_idx  = '0;
      for (int i = 0; i < int'(REQ_NUM); i++) begin
         cand_idx = IdxW'((int'(rr_q) + i + 1) % int'(REQ_NUM));
         if (req[cand_idx] &&
             (!win_found || pri[cand_idx*PRI_WIDTH +: PRI_WIDTH] > win_pri)) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
            win_pri   = pri[cand_idx*PRI_WIDTH +: PRI_WIDTH];
         end
      end
   end

   // The round-robin pointer doubles as the owner index while in StOwn.
   assign own_htrans = htrans[rr_q*2 +: 2];
   assign own_hburst = hburst[rr_q*3 +: 3];
   assign own_lock   = hmastlock[rr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         addr_sel_q  <= '0;
         data_sel_q  <= '0;
         locked_q    <= 1'b0;
         beats_q     <= '0;
         incr_open_q <= 1'b0;
         rr_q        <= '0;
`ifdef CM_ARB_INCR_LIMIT_EN
         incr_cnt_q  <= '0;
`endif
      end else if (hready) begin
         state_q     <= state_d;
         addr_sel_q  <= addr_sel_d;
         data_sel_q  <= addr_sel_q;
         locked_q    <= locked_d;
         beats_q     <= beats_d;
         incr_open_q <= incr_open_d;
         rr_q        <= rr_d;
`ifdef CM_ARB_INCR_LIMIT_EN
         incr_cnt_q  <= incr_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_sel_d  = addr_sel_q;
      rr_d        = rr_q;
      beats_d     = beats_q;
      incr_open_d = incr_open_q;
      locked_d    = locked_q;
      force_end   = 1'b0;
`ifdef CM_ARB_INCR_LIMIT_EN
      incr_cnt_d  = incr_cnt_q;
`endif

      if (state_q == StOwn) begin
         unique case (own_htrans)
            TrNonseq: begin
               unique case (own_hburst[2:1])
                  2'b00:   beats_d = 4'd0;
                  2'b01:   beats_d = 4'd3;
                  2'b10:   beats_d = 4'd7;
                  default: beats_d = 4'd15;
               endcase
               incr_open_d = (own_hburst == BurstIncr);
               locked_d    = own_lock;
            end
            TrSeq: begin
               beats_d  = (beats_q == 4'd0) ? 4'd0 : beats_q - 4'd1;
               locked_d = own_lock;
            end
            TrBusy: ;
            default: begin
               incr_open_d = 1'b0;
               if (!own_lock) locked_d = 1'b0;
            end
         endcase

`ifdef CM_ARB_INCR_LIMIT_EN
         if (own_htrans == TrNonseq) begin
            incr_cnt_d = (own_hburst == BurstIncr) ? IncrCntW'(1) : '0;
         end else if (own_htrans == TrSeq && incr_open_q) begin
            if (incr_cnt_q != IncrCntW'(INCR_MAX_BEATS)) incr_cnt_d = incr_cnt_q + 1'b1;
         end else if (own_htrans != TrBusy) begin
            incr_cnt_d = '0;
         end
         force_end = (incr_cnt_q >= IncrCntW'(INCR_MAX_BEATS)) && |(req & ~addr_sel_q) &&
                     !locked_d;
`endif
      end

      tenure_end = (beats_d == 4'd0) && !incr_open_d && !locked_d &&
                   (own_htrans == TrIdle ||
                    (own_htrans == TrNonseq && own_hburst == BurstSingle));

      if ((state_q == StIdle && win_found) || (state_q == StOwn && (tenure_end || force_end))) begin
         beats_d     = '0;
         incr_open_d = 1'b0;
         locked_d    = 1'b0;
`ifdef CM_ARB_INCR_LIMIT_EN
         incr_cnt_d  = '0;
`endif
         if (win_found) begin
            state_d             = StOwn;
            addr_sel_d          = '0;
            addr_sel_d[win_idx] = 1'b1;
            rr_d                = win_idx;
         end else begin
            state_d    = StIdle;
            addr_sel_d = '0;
         end
      end
   end

   always_comb begin
      addr_sel = addr_sel_q;
      data_sel = data_sel_q;
      locked   = locked_q;
   end

endmodule

// File: tb/tb_cm_arb_burst_ctrl.sv
// Directed bench for cm_arb_burst_ctrl with two masters; expectations are hand-derived per step.
module tb_cm_arb_burst_ctrl;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] SEQ    = 2'b11;
   localparam logic [1:0] NONSEQ = 2'b10;
   localparam logic [2:0] SINGLE = 3'b000;
   localparam logic [2:0] INCR   = 3'b001;
   localparam logic [2:0] INCR4  = 3'b011;
   localparam logic [2:0] INCR8  = 3'b101;
   localparam logic [2:0] INCR16 = 3'b111;

   logic       clk;
   logic       rst_n;
   logic [1:0] req;
   logic [3:0] pri;
   logic [3:0] htrans;
   logic [5:0] hburst;
   logic [1:0] hmastlock;
   logic       hready;
   logic [1:0] addr_sel;
   logic [1:0] data_sel;
   logic       locked;

   int checks = 0;
   int errors = 0;

   cm_arb_burst_ctrl #(
      .REQ_NUM       (2),
      .PRI_WIDTH     (2),
      .INCR_MAX_BEATS(4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .pri      (pri),
      .htrans   (htrans),
      .hburst   (hburst),
      .hmastlock(hmastlock),
      .hready   (hready),
      .addr_sel (addr_sel),
      .data_sel (data_sel),
      .locked   (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_m(input int m, input logic r, input logic [1:0] p, input logic [1:0] tr,
                        input logic [2:0] hb, input logic lk);
      req[m]           = r;
      pri[m*2 +: 2]    = p;
      htrans[m*2 +: 2] = tr;
      hburst[m*3 +: 3] = hb;
      hmastlock[m]     = lk;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; req = '0; pri = '0; htrans = '0; hburst = '0; hmastlock = '0; hready = 1'b1;
      #3;
      check("rst_addr", {2'b0, addr_sel}, 4'h0);
      check("rst_data", {2'b0, data_sel}, 4'h0);
      check("rst_lock", {3'b0, locked}, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Equal priority, back-to-back SINGLE transfers alternate owners
      set_m(0, 1'b1, 2'd1, NONSEQ, SINGLE, 1'b0);
      set_m(1, 1'b0, 2'd1, NONSEQ, SINGLE, 1'b0);
      tick(); check("t1_a_addr", {2'b0, addr_sel}, 4'h1); check("t1_a_data", {2'b0, data_sel}, 4'h0);
      set_m(1, 1'b1, 2'd1, NONSEQ, SINGLE, 1'b0);
      tick(); check("t1_b_addr", {2'b0, addr_sel}, 4'h2); check("t1_b_data", {2'b0, data_sel}, 4'h1);
      tick(); check("t1_c_addr", {2'b0, addr_sel}, 4'h1); check("t1_c_data", {2'b0, data_sel}, 4'h2);
      tick(); check("t1_d_addr", {2'b0, addr_sel}, 4'h2); check("t1_d_data", {2'b0, data_sel}, 4'h1);
      set_m(0, 1'b0, 2'd1, IDLE, SINGLE, 1'b0);
      set_m(1, 1'b0, 2'd1, IDLE, SINGLE, 1'b0);
      tick(); check("t1_idle", {2'b0, addr_sel}, 4'h0);

      // INCR4 holds against a higher-priority requester until its end
      set_m(0, 1'b1, 2'd1, NONSEQ, INCR4, 1'b0);
      set_m(1, 1'b0, 2'd3, IDLE, SINGLE, 1'b0);
      tick(); check("t2_grant", {2'b0, addr_sel}, 4'h1);
      tick(); check("t2_beat1", {2'b0, addr_sel}, 4'h1);
      set_m(0, 1'b1, 2'd1, SEQ, INCR4, 1'b0);
      set_m(1, 1'b1, 2'd3, IDLE, SINGLE, 1'b0);
      tick(); check("t2_beat2", {2'b0, addr_sel}, 4'h1);
      tick(); check("t2_beat3", {2'b0, addr_sel}, 4'h1);
      tick(); check("t2_beat4", {2'b0, addr_sel}, 4'h1);
      set_m(0, 1'b0, 2'd1, IDLE, INCR4, 1'b0);
      tick(); check("t2_switch", {2'b0, addr_sel}, 4'h2); check("t2_data", {2'b0, data_sel}, 4'h1);

      // INCR8 then wait states on the final data phase
      set_m(1, 1'b0, 2'd3, IDLE, SINGLE, 1'b0);
      tick(); check("t3_idle", {2'b0, addr_sel}, 4'h0);
      set_m(0, 1'b1, 2'd1, NONSEQ, INCR8, 1'b0);
      tick(); check("t3_grant", {2'b0, addr_sel}, 4'h1);
      tick();
      set_m(0, 1'b1, 2'd1, SEQ, INCR8, 1'b0);
      for (int k = 0; k < 7; k++) tick();
      check("t3_last", {2'b0, addr_sel}, 4'h1);
      set_m(0, 1'b0, 2'd1, IDLE, INCR8, 1'b0);
      set_m(1, 1'b1, 2'd3, IDLE, SINGLE, 1'b0);
      hready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t3_wait_addr", {2'b0, addr_sel}, 4'h1);
         check("t3_wait_data", {2'b0, data_sel}, 4'h1);
      end
      hready = 1'b1;
      tick(); check("t3_switch", {2'b0, addr_sel}, 4'h2); check("t3_data", {2'b0, data_sel}, 4'h1);

      // Locked sequence holds until IDLE with HMASTLOCK low
      set_m(1, 1'b0, 2'd3, IDLE, SINGLE, 1'b0);
      tick(); check("t4_idle", {2'b0, addr_sel}, 4'h0);
      set_m(0, 1'b1, 2'd1, NONSEQ, SINGLE, 1'b1);
      tick(); check("t4_grant", {2'b0, addr_sel}, 4'h1);
      set_m(1, 1'b1, 2'd3, IDLE, SINGLE, 1'b0);
      tick(); check("t4_s1_addr", {2'b0, addr_sel}, 4'h1); check("t4_s1_lock", {3'b0, locked}, 4'h1);
      tick(); check("t4_s2_addr", {2'b0, addr_sel}, 4'h1); check("t4_s2_lock", {3'b0, locked}, 4'h1);
      set_m(0, 1'b1, 2'd1, IDLE, SINGLE, 1'b1);
      tick(); check("t4_il_addr", {2'b0, addr_sel}, 4'h1); check("t4_il_lock", {3'b0, locked}, 4'h1);
      set_m(0, 1'b0, 2'd1, IDLE, SINGLE, 1'b0);
      tick(); check("t4_rel_addr", {2'b0, addr_sel}, 4'h2); check("t4_rel_lock", {3'b0, locked}, 4'h0);

      // Asynchronous reset in the middle of an INCR16
      set_m(1, 1'b0, 2'd3, IDLE, SINGLE, 1'b0);
      tick(); check("t5_idle", {2'b0, addr_sel}, 4'h0);
      set_m(0, 1'b1, 2'd1, NONSEQ, INCR16, 1'b1);
      tick(); check("t5_grant", {2'b0, addr_sel}, 4'h1);
      tick();
      set_m(0, 1'b1, 2'd1, SEQ, INCR16, 1'b1);
      tick(); check("t5_beat2_lock", {3'b0, locked}, 4'h1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_addr", {2'b0, addr_sel}, 4'h0);
      check("t5_rst_data", {2'b0, data_sel}, 4'h0);
      check("t5_rst_lock", {3'b0, locked}, 4'h0);
      set_m(0, 1'b0, 2'd1, IDLE, SINGLE, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t5_post_addr", {2'b0, addr_sel}, 4'h0);
      end

      // Undefined-length INCR with a competing requester
      set_m(0, 1'b1, 2'd1, IDLE, SINGLE, 1'b0);
      tick(); check("t6_grant", {2'b0, addr_sel}, 4'h1);
      set_m(1, 1'b1, 2'd1, IDLE, SINGLE, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         if (k == 1) set_m(0, 1'b1, 2'd1, NONSEQ, INCR, 1'b0);
         else        set_m(0, 1'b1, 2'd1, SEQ, INCR, 1'b0);
         tick();
`ifdef CM_ARB_INCR_LIMIT_EN
         check("t6_beat", {2'b0, addr_sel}, (k <= 4) ? 4'h1 : 4'h2);
         if (k == 5) break;
`else
         check("t6_beat", {2'b0, addr_sel}, 4'h1);
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
